// File: rtl/fifo_rd_adapter.sv
// ---------------------------------------------------------------------------
// fifo_rd_adapter
// Read-side adapter for the synchronous FIFO of the out-of-order pipeline.
// Issues dequeues toward the FIFO, absorbs its one-cycle registered read
// latency and hands the words to the issue/dispatch logic as a valid/ready
// stream. A 2-entry output buffer gives full throughput with lossless
// backpressure: a dequeue is only issued when the word it produces is
// guaranteed a free slot on arrival.
// ---------------------------------------------------------------------------
module fifo_rd_adapter #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  fifo_empty,
    output logic                  fifo_deq,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [1:0]            occupancy
);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] r_slot0;      // head of the buffer, drives out_data
    logic [DATA_WIDTH-1:0] r_slot1;      // second entry
    logic [1:0]            r_occ;        // words held (0..2)
    logic                  r_inflight;   // fifo_data carries a dequeued word this cycle
    logic                  r_out_valid;  // registered copy of (r_occ != 0)

    // -----------------------------------------------------------------------
    // Combinational control
    // -----------------------------------------------------------------------
    logic                  w_pop;
    logic                  w_capture;
    logic [2:0]            w_level;
    logic                  w_deq;
    logic [DATA_WIDTH-1:0] w_slot0_nxt;
    logic [DATA_WIDTH-1:0] w_slot1_nxt;
    logic [1:0]            w_occ_nxt;

    // Handshake, capture and issue decisions for the current cycle
    always_comb begin
        w_pop     = r_out_valid & out_ready & ~flush;
        w_capture = r_inflight & ~flush;
        // Level after this edge, counting the in-flight word; 3 bits so the
        // subtraction of a pop can never wrap.
        w_level   = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
        // resetn is folded in so the request drops at once on reset assertion.
        w_deq     = resetn & ~flush & ~fifo_empty & (w_level < 3'd2);
    end

    // Next-state of the buffer: capture of the arriving word and/or pop of the head
    always_comb begin
        w_slot0_nxt = r_slot0;
        w_slot1_nxt = r_slot1;
        w_occ_nxt   = r_occ;
        if (flush) begin
            // Contents become don't-care; only the count matters.
            w_occ_nxt = 2'd0;
        end else begin
            case ({w_capture, w_pop})
                2'b10: begin
                    // Arriving word lands in the first free slot.
                    case (r_occ)
                        2'd0: begin
                            w_slot0_nxt = fifo_data;
                            w_occ_nxt   = 2'd1;
                        end
                        2'd1: begin
                            w_slot1_nxt = fifo_data;
                            w_occ_nxt   = 2'd2;
                        end
                        default: begin
                            // Full buffer with a word arriving is excluded by
                            // the issue rule; hold rather than corrupt.
                            w_occ_nxt = r_occ;
                        end
                    endcase
                end
                2'b01: begin
                    // Head leaves, second entry moves up.
                    w_slot0_nxt = r_slot1;
                    w_occ_nxt   = r_occ - 2'd1;
                end
                2'b11: begin
                    // Head leaves and a new word arrives in the same cycle.
                    case (r_occ)
                        2'd1: begin
                            w_slot0_nxt = fifo_data;
                        end
                        2'd2: begin
                            w_slot0_nxt = r_slot1;
                            w_slot1_nxt = fifo_data;
                        end
                        default: begin
                            // A pop from an empty buffer cannot happen.
                            w_occ_nxt = r_occ;
                        end
                    endcase
                end
                default: begin
                    // Nothing arrives, nothing leaves.
                    w_occ_nxt = r_occ;
                end
            endcase
        end
    end

    // Buffer registers, in-flight tracking and registered output flag
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_slot0     <= {DATA_WIDTH{1'b0}};
            r_slot1     <= {DATA_WIDTH{1'b0}};
            r_occ       <= 2'd0;
            r_inflight  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_slot0     <= w_slot0_nxt;
            r_slot1     <= w_slot1_nxt;
            r_occ       <= w_occ_nxt;
            // w_deq is already low during flush, so no word is left in flight.
            r_inflight  <= w_deq;
            r_out_valid <= (w_occ_nxt != 2'd0);
        end
    end

    // -----------------------------------------------------------------------
    // Outputs: everything except the dequeue request comes straight from flops
    // -----------------------------------------------------------------------
    assign fifo_deq  = w_deq;
    assign out_valid = r_out_valid;
    assign out_data  = r_slot0;
    assign occupancy = r_occ;

endmodule
